// File: rtl/dm_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported data memory.
// Issues one command (CMD) then a response cycle (RESP); supports a per-requester lock for RMW.
module dm_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] ad0,
  input  logic [31:0] ad1,
  input  logic [31:0] wrdata0,
  input  logic [31:0] wrdata1,
  input  logic [2:0]  memwr0,
  input  logic [2:0]  memwr1,
  input  logic [1:0]  cut0,
  input  logic [1:0]  cut1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        lock_to,
  output logic        busy,
  output logic [31:0] mem_ad,
  output logic [31:0] mem_wrdata,
  output logic [2:0]  mem_memwr,
  output logic [1:0]  mem_cut,
  input  logic [31:0] mem_dm
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          locked_q, locked_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_to_q, lock_to_d;
  logic          cw_q, cw_d;
  logic [31:0]   c_ad_q, c_ad_d;
  logic [31:0]   c_wd_q, c_wd_d;
  logic [2:0]    c_wr_q, c_wr_d;
  logic [1:0]    c_cut_q, c_cut_d;
  logic          c_lock_q, c_lock_d;

  logic lk_eff, own_eff;
  logic elig0, elig1, win_any, win;
  logic owner_req, c_is_rd;

  assign owner_req = owner_q ? req1 : req0;
  assign c_is_rd   = (c_wr_q == 3'd0) || (c_wr_q > 3'd4);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    lock_to_d = 1'b0;
    cw_d      = cw_q;
    c_ad_d    = c_ad_q;
    c_wd_d    = c_wd_q;
    c_wr_d    = c_wr_q;
    c_cut_d   = c_cut_q;
    c_lock_d  = c_lock_q;

    // In RESP the current access completes on this edge, so arbitrate against
    // the lock state it leaves behind (lets the other side win on release).
    lk_eff  = locked_q;
    own_eff = owner_q;
    if (state_q == RESP) begin
      if (c_lock_q) begin
        lk_eff  = 1'b1;
        own_eff = cw_q;
      end else if (locked_q && (owner_q == cw_q)) begin
        lk_eff = 1'b0;
      end
    end
    locked_d = lk_eff;
    owner_d  = own_eff;

    elig0   = req0 && (!lk_eff || !own_eff);
    elig1   = req1 && (!lk_eff ||  own_eff);
    win_any = elig0 || elig1;
    win     = (elig0 && elig1) ? ~last_q : elig1;

    case (state_q)
      CMD:     state_d = RESP;
      default: begin
        if (win_any) begin
          state_d  = CMD;
          last_d   = win;
          cw_d     = win;
          c_ad_d   = win ? ad1     : ad0;
          c_wd_d   = win ? wrdata1 : wrdata0;
          c_wr_d   = win ? memwr1  : memwr0;
          c_cut_d  = win ? cut1    : cut0;
          c_lock_d = win ? lock1   : lock0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // Idle-owner watchdog: counting and owner grants are mutually exclusive
    // because a grant needs the owner's req high.
    if (!locked_q) begin
      cnt_d = '0;
    end else if ((state_q != CMD) && win_any && (win == owner_q)) begin
      cnt_d = '0;
    end else if ((state_q == IDLE) && !owner_req) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        locked_d  = 1'b0;
        lock_to_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      locked_q  <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      lock_to_q <= 1'b0;
      cw_q      <= 1'b0;
      c_ad_q    <= '0;
      c_wd_q    <= '0;
      c_wr_q    <= '0;
      c_cut_q   <= '0;
      c_lock_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      locked_q  <= locked_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      lock_to_q <= lock_to_d;
      cw_q      <= cw_d;
      c_ad_q    <= c_ad_d;
      c_wd_q    <= c_wd_d;
      c_wr_q    <= c_wr_d;
      c_cut_q   <= c_cut_d;
      c_lock_q  <= c_lock_d;
    end
  end

  // Memory-facing outputs are zero in IDLE so an idle cycle is a harmless read of word 0.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    rdata      = '0;
    mem_ad     = '0;
    mem_wrdata = '0;
    mem_memwr  = '0;
    mem_cut    = '0;
    case (state_q)
      CMD: begin
        gnt0       = ~cw_q;
        gnt1       = cw_q;
        mem_ad     = c_ad_q;
        mem_wrdata = c_wd_q;
        mem_memwr  = (c_wr_q > 3'd4) ? 3'd0 : c_wr_q;
        mem_cut    = c_cut_q;
      end
      RESP: begin
        mem_ad  = c_ad_q;
        mem_cut = c_cut_q;
        if (c_is_rd) begin
          rvalid0 = ~cw_q;
          rvalid1 = cw_q;
          rdata   = mem_dm;
        end
      end
      default: ;
    endcase
  end

  assign lock_to = lock_to_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the single-ported data memory (`Datamemory`). It arbitrates between requester 0 (CPU load/store unit) and requester 1 (DMA/debug port) and drives one memory command at a time. It returns read data one cycle after each command, since memory reads are registered on `Clk`. It also provides a lock so that one requester can perform an uninterrupted read-modify-write sequence.

## Interface
- `LOCK_TIMEOUT`, default 16: idle cycles allowed to a lock owner before the lock is force-released. Minimum value is 1.
- `Clk`  in  1  clock
- `Reset`  in  1  asynchronous, active-high
- `req0`, `req1`  in  1  access request; hold it, with its command, stable until the matching `gnt`
- `ad0`, `ad1`  in  32  word address
- `wrdata0`, `wrdata1`  in  32  write data
- `memwr0`, `memwr1`  in  3  access code: 0 read, 1 word write, 2 byte write, 3 atomic word write, 4 halfword write
- `cut0`, `cut1`  in  2  read width: 0 word, 1 byte zero-extended, 2 halfword zero-extended
- `lock0`, `lock1`  in  1  acquire or keep the lock through this access
- `gnt0`, `gnt1`  out  1  one-cycle pulse: the command is being issued this cycle
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdata` is valid for a read
- `rdata`  out  32  read data, shared by both requesters, qualified by `rvalid0`/`rvalid1`
- `lock_to`  out  1  one-cycle pulse: a lock timeout forced the release
- `busy`  out  1  high when the state is not IDLE
- `mem_ad`  out  32  address to the memory
- `mem_wrdata`  out  32  write data to the memory
- `mem_memwr`  out  3  access code to the memory
- `mem_cut`  out  2  read-width select to the memory
- `mem_dm`  in  32  memory read data; valid in the cycle after a read command

## Operation
- **FSM states**: IDLE, CMD, RESP.
- **Arbitration** happens on a clock edge while the state is IDLE or RESP:
  - The eligible requests are taken from `req0`/`req1`, masked by lock ownership.
  - On a win, the winner's `ad`, `wrdata`, `memwr`, `cut` and `lock` are captured into a command register, and the next state is CMD.
  - If no request is eligible, the next state is IDLE.
- **Round robin**: `last` holds the most recent winner and resets to 1. On contention, the requester that is not `last` wins. A single eligible requester wins regardless of `last`.
- **CMD** (always one cycle):
  - `gnt<w>` = 1.
  - `mem_memwr` = the captured code; codes 5–7 are forwarded as 0 (read).
  - `mem_ad`, `mem_wrdata` and `mem_cut` carry the captured values.
  - Next state is RESP.
- **RESP** (always one cycle):
  - `mem_memwr` = 0.
  - `mem_ad` and `mem_cut` keep the captured values, so `mem_dm` stays stable.
  - For a read: `rvalid<w>` = 1 and `rdata` = `mem_dm`, passed through combinationally.
  - For writes, `rvalid` stays 0.
- **Lock**:
  - A completed access with `lock` = 1 makes its requester the owner: `locked` = 1, `owner` = w.
  - While locked, only the owner's request is eligible.
  - A completed owner access with `lock` = 0 releases the lock at the end of its RESP. The other requester can then be arbitrated on that same edge.
  - Code 3 does not imply a lock.
- **Timeout**:
  - While `locked` = 1, the state is IDLE and the owner's `req` is low, a counter increments every cycle. It clears whenever the owner is granted.
  - When the count reaches `LOCK_TIMEOUT`, the lock clears and `lock_to` pulses in the next cycle.
- **Idle output values**: in IDLE, `mem_ad`, `mem_wrdata`, `mem_memwr` and `mem_cut` are 0. An idle read of address 0 has no side effect.

## Timing
- **Reset values**: all outputs 0. State = IDLE, `last` = 1, `locked` = 0, counter = 0.
- **Reset mid-operation**: an issued write may or may not complete. No `gnt` or `rvalid` pulse is generated after `Reset` rises.
- **Read latency**: request sampled at edge E → `gnt` in the cycle after E (CMD) → `rvalid` with data in the following cycle (RESP).
- **Throughput**: back-to-back accesses issue one CMD every 2 cycles, because RESP arbitrates directly into CMD.
- **Dropped requests**: a request withdrawn before it is granted is simply not served. It is never granted later.
- **Release-cycle contention**: if the owner releases the lock in RESP while the other requester is waiting, the other requester wins on that edge, even if the owner re-requests.

## Test plan
- **Single read**: memory[5] = 0xA5A51234; `req0` read `ad0` = 5, `cut0` = 0 → `gnt0` in cycle 1, `mem_memwr` = 0; `rvalid0` in cycle 2 with `rdata` = 0xA5A51234. Repeat with `cut0` = 1 → `rdata` = 0x00000034.
- **Contention after reset**: `req0` writes word 0x11 to address 1 while `req1` writes word 0x22 to address 2, both simultaneously → `gnt0` first and `gnt1` exactly 2 cycles later. Both memory words are correct, and grants alternate for repeated contention.
- **Lock sequence**: `req0` read address 3 with `lock0` = 1, with `req1` pending → `req1` is not granted while `req0` issues a write 0x7 to address 3 with `lock0` = 0. `gnt1` arrives in the CMD cycle right after that write's RESP.
- **Lock timeout** (`LOCK_TIMEOUT` = 4): `req0` locks, then goes idle while `req1` is held high → `lock_to` pulses after 4 idle cycles, and `gnt1` follows.
- **Reset mid-CMD**: assert `Reset` during CMD → all outputs 0 immediately, with no `rvalid`. After release, contention grants `req0` first.
- **Invalid code**: `memwr0` = 6 at address 5 → `mem_memwr` = 0 in CMD, `rvalid0` in RESP, and memory is unchanged.
